// File: rtl/lectura_bmp_stream.sv
// BMP pixel-array reader: fetches 6 bytes per pair from byte-wide memory and emits two RGB pixels per hsync beat, top row first.
// Optional LECTURA_GRAY_EN: replaces each pixel with Y = (R + 2G + B) >> 2 on all three channels.
module lectura_bmp_stream #(
    parameter int WIDTH      = 500,
    parameter int HEIGHT     = 500,
    parameter int BASE_ADDR  = 54,
    parameter int ADDR_W     = 20,
    parameter int VSYNC_LEN  = 4,
    parameter int HBLANK_LEN = 16
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_dout,
    output logic              vsync,
    output logic              hsync,
    output logic [7:0]        DATA_R0,
    output logic [7:0]        DATA_G0,
    output logic [7:0]        DATA_B0,
    output logic [7:0]        DATA_R1,
    output logic [7:0]        DATA_G1,
    output logic [7:0]        DATA_B1,
    output logic              busy,
    output logic              Read_Done
);

    localparam int STRIDE = ((WIDTH * 3 + 3) / 4) * 4;
    localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0] TOP_BASE = ADDR_W'(BASE_ADDR + (HEIGHT - 1) * STRIDE);
    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
    localparam logic [15:0] LAST_PAIR = 16'(WIDTH / 2 - 1);
    localparam logic [15:0] LAST_ROW  = 16'(HEIGHT - 1);
    localparam logic [15:0] VS_LAST   = 16'(VSYNC_LEN - 1);
    localparam logic [15:0] HB_LAST   = 16'(HBLANK_LEN - 1);

    if (WIDTH % 2 != 0) begin : g_width_check
        $error("lectura_bmp_stream: WIDTH must be even");
    end
    if (VSYNC_LEN < 1) begin : g_vsync_check
        $error("lectura_bmp_stream: VSYNC_LEN must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_VSYNC, S_FETCH, S_LAST, S_EMIT, S_HBLANK, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [15:0]       pair_q, pair_d;
    logic [15:0]       row_q, row_d;
    logic [2:0]        k_q, k_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] off_q, off_d;
    logic [4:0][7:0]   bytes_q, bytes_d;
    logic [7:0]        r0_q, g0_q, b0_q, r1_q, g1_q, b1_q;
    logic [7:0]        r0_d, g0_d, b0_d, r1_d, g1_d, b1_d;

`ifdef LECTURA_GRAY_EN
    logic [9:0] sum0, sum1;
    // Byte 5 (R1) is still on mem_dout during LAST, so pixel 1 takes it directly.
    assign sum0 = {2'b00, bytes_q[2]} + {1'b0, bytes_q[1], 1'b0} + {2'b00, bytes_q[0]};
    assign sum1 = {2'b00, mem_dout}   + {1'b0, bytes_q[4], 1'b0} + {2'b00, bytes_q[3]};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pair_d  = pair_q;
        row_d   = row_q;
        k_d     = k_q;
        base_d  = base_q;
        off_d   = off_q;
        bytes_d = bytes_q;
        r0_d = r0_q; g0_d = g0_q; b0_d = b0_q;
        r1_d = r1_q; g1_d = g1_q; b1_d = b1_q;
        mem_rd  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_VSYNC;
                    cnt_d   = '0;
                    pair_d  = '0;
                    row_d   = '0;
                    k_d     = '0;
                    base_d  = TOP_BASE;
                    off_d   = '0;
                end
            end
            S_VSYNC: begin
                if (cnt_q == VS_LAST) begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_FETCH: begin
                mem_rd = 1'b1;
                off_d  = off_q + ONE_A;
                if (k_q != 3'd0)
                    bytes_d = {mem_dout, bytes_q[4:1]};
                if (k_q == 3'd5) begin
                    state_d = S_LAST;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            S_LAST: begin
                state_d = S_EMIT;
`ifdef LECTURA_GRAY_EN
                r0_d = sum0[9:2]; g0_d = sum0[9:2]; b0_d = sum0[9:2];
                r1_d = sum1[9:2]; g1_d = sum1[9:2]; b1_d = sum1[9:2];
`else
                b0_d = bytes_q[0]; g0_d = bytes_q[1]; r0_d = bytes_q[2];
                b1_d = bytes_q[3]; g1_d = bytes_q[4]; r1_d = mem_dout;
`endif
            end
            S_EMIT: begin
                if (pair_q != LAST_PAIR) begin
                    pair_d  = pair_q + 16'd1;
                    state_d = S_FETCH;
                end else begin
                    pair_d = '0;
                    off_d  = '0;
                    base_d = base_q - STRIDE_A;
                    cnt_d  = '0;
                    if (row_q == LAST_ROW) begin
                        state_d = S_DONE;
                    end else begin
                        row_d   = row_q + 16'd1;
                        state_d = (HBLANK_LEN == 0) ? S_FETCH : S_HBLANK;
                    end
                end
            end
            S_HBLANK: begin
                if (cnt_q == HB_LAST) begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pair_q  <= '0;
            row_q   <= '0;
            k_q     <= '0;
            base_q  <= '0;
            off_q   <= '0;
            bytes_q <= '0;
            r0_q <= '0; g0_q <= '0; b0_q <= '0;
            r1_q <= '0; g1_q <= '0; b1_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pair_q  <= pair_d;
            row_q   <= row_d;
            k_q     <= k_d;
            base_q  <= base_d;
            off_q   <= off_d;
            bytes_q <= bytes_d;
            r0_q <= r0_d; g0_q <= g0_d; b0_q <= b0_d;
            r1_q <= r1_d; g1_q <= g1_d; b1_q <= b1_d;
        end
    end

    assign mem_addr  = (state_q == S_FETCH) ? (base_q + off_q) : '0;
    assign vsync     = (state_q == S_VSYNC);
    assign hsync     = (state_q == S_EMIT);
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign Read_Done = (state_q == S_DONE);
    assign DATA_R0 = r0_q;
    assign DATA_G0 = g0_q;
    assign DATA_B0 = b0_q;
    assign DATA_R1 = r1_q;
    assign DATA_G1 = g1_q;
    assign DATA_B1 = b1_q;

endmodule

// File: tb/tb_lectura_bmp_stream.sv
// Bench for lectura_bmp_stream: 4x2 frame timing/data via scoreboard, restart, busy start, mid-frame reset, 6-wide stride.
module tb_lectura_bmp_stream;

    logic HCLK = 1'b0;
    logic HRESET = 1'b1;
    logic start = 1'b0;
    logic start6 = 1'b0;

    always #5 HCLK = ~HCLK;

    logic [19:0] mem_addr, mem_addr6;
    logic        mem_rd, mem_rd6;
    logic [7:0]  mem_dout = 8'h00, mem_dout6 = 8'h00;
    logic        vsync, hsync, busy, Read_Done;
    logic        vsync6, hsync6, busy6, Read_Done6;
    logic [7:0]  R0, G0, B0, R1, G1, B1;
    logic [7:0]  R0_6, G0_6, B0_6, R1_6, G1_6, B1_6;

    lectura_bmp_stream #(
        .WIDTH(4), .HEIGHT(2), .BASE_ADDR(54), .ADDR_W(20), .VSYNC_LEN(4), .HBLANK_LEN(16)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .start(start),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_dout(mem_dout),
        .vsync(vsync), .hsync(hsync),
        .DATA_R0(R0), .DATA_G0(G0), .DATA_B0(B0),
        .DATA_R1(R1), .DATA_G1(G1), .DATA_B1(B1),
        .busy(busy), .Read_Done(Read_Done)
    );

    lectura_bmp_stream #(
        .WIDTH(6), .HEIGHT(2), .BASE_ADDR(54), .ADDR_W(20), .VSYNC_LEN(4), .HBLANK_LEN(16)
    ) dut6 (
        .HCLK(HCLK), .HRESET(HRESET), .start(start6),
        .mem_addr(mem_addr6), .mem_rd(mem_rd6), .mem_dout(mem_dout6),
        .vsync(vsync6), .hsync(hsync6),
        .DATA_R0(R0_6), .DATA_G0(G0_6), .DATA_B0(B0_6),
        .DATA_R1(R1_6), .DATA_G1(G1_6), .DATA_B1(B1_6),
        .busy(busy6), .Read_Done(Read_Done6)
    );

    // Memory model: each byte reads back its own low address byte one cycle later.
    always @(posedge HCLK) begin
        if (mem_rd)  mem_dout  <= mem_addr[7:0];
        if (mem_rd6) mem_dout6 <= mem_addr6[7:0];
    end

    int edge_cnt = 0;
    always @(posedge HCLK) edge_cnt <= edge_cnt + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int         cyc;
        logic [47:0] data;   // {R0,G0,B0,R1,G1,B1}
    } pair_t;

    pair_t sb[$];
    int    addr_q[$];

    task automatic push_frame();
        pair_t e;
        int    b[6];
        int    y0, y1;
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < 2; p++) begin
                for (int k = 0; k < 6; k++)
                    b[k] = (54 + (1 - r) * 12 + 6 * p + k) & 255;
                e.cyc = 12 + r * 32 + 8 * p;
`ifdef LECTURA_GRAY_EN
                y0 = ((b[2] + 2 * b[1] + b[0]) >> 2) & 255;
                y1 = ((b[5] + 2 * b[4] + b[3]) >> 2) & 255;
                e.data = {8'(y0), 8'(y0), 8'(y0), 8'(y1), 8'(y1), 8'(y1)};
`else
                y0 = 0; y1 = 0;
                e.data = {8'(b[2]), 8'(b[1]), 8'(b[0]), 8'(b[5]), 8'(b[4]), 8'(b[3])};
`endif
                sb.push_back(e);
            end
        end
    endtask

    task automatic test_reset();
        logic [47:0] d;
        HRESET = 1'b1;
        start  = 1'b1;
        repeat (3) @(negedge HCLK);
        d = {R0, G0, B0, R1, G1, B1};
        n_cmp++;
        if ({vsync, hsync, busy, Read_Done, mem_rd, mem_addr, d} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got v=%b h=%b busy=%b done=%b rd=%b addr=%h data=%h want all zero",
                     vsync, hsync, busy, Read_Done, mem_rd, mem_addr, d);
        end
        HRESET = 1'b0;
        start  = 1'b0;
        @(negedge HCLK);
        n_cmp++;
        if ({busy, vsync} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_start_ignored got busy=%b vsync=%b want 0 0", busy, vsync);
        end
    endtask

    task automatic test_frame(input int pulse_rel);
        pair_t e;
        int    n, rel, hs;
        logic  exp_vs, exp_busy, exp_done;
        sb.delete();
        push_frame();
        hs = 0;
        @(negedge HCLK);
        start = 1'b1;
        n = edge_cnt + 1;
        for (int i = 0; i < 60; i++) begin
            @(negedge HCLK);
            rel = edge_cnt + 1 - n;
            start = (rel == pulse_rel);
            exp_vs   = (rel >= 1) && (rel <= 4);
            exp_busy = (rel >= 1) && (rel <= 52);
            exp_done = (rel >= 53);
            n_cmp++;
            if (vsync !== exp_vs) begin
                n_bad++;
                $display("FAIL vsync rel=%0d got %b want %b", rel, vsync, exp_vs);
            end
            n_cmp++;
            if (busy !== exp_busy) begin
                n_bad++;
                $display("FAIL busy rel=%0d got %b want %b", rel, busy, exp_busy);
            end
            n_cmp++;
            if (Read_Done !== exp_done) begin
                n_bad++;
                $display("FAIL read_done rel=%0d got %b want %b", rel, Read_Done, exp_done);
            end
            if (hsync === 1'b1) begin
                hs++;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL extra_hsync rel=%0d got pulse want none", rel);
                end else begin
                    e = sb.pop_front();
                    if (rel !== e.cyc) begin
                        n_bad++;
                        $display("FAIL hsync_time got rel=%0d want rel=%0d", rel, e.cyc);
                    end
                    n_cmp++;
                    if ({R0, G0, B0, R1, G1, B1} !== e.data) begin
                        n_bad++;
                        $display("FAIL pair_data rel=%0d got %h want %h", rel,
                                 {R0, G0, B0, R1, G1, B1}, e.data);
                    end
                end
            end
        end
        start = 1'b0;
        n_cmp++;
        if (hs !== 4 || sb.size() != 0) begin
            n_bad++;
            $display("FAIL hsync_count got %0d (left %0d) want 4 (left 0)", hs, sb.size());
        end
    endtask

    task automatic test_first_frame();
        test_frame(0);
    endtask

    task automatic test_done_restart();
        n_cmp++;
        if (Read_Done !== 1'b1) begin
            n_bad++;
            $display("FAIL done_sticky got %b want 1", Read_Done);
        end
        test_frame(0);
    endtask

    task automatic test_busy_start();
        test_frame(30);
    endtask

    task automatic test_reset_midframe();
        int          n, rel;
        logic [47:0] d;
        @(negedge HCLK);
        start = 1'b1;
        n = edge_cnt + 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge HCLK);
            start = 1'b0;
            rel = edge_cnt + 1 - n;
            if (rel == 15) HRESET = 1'b1;
            if (rel == 16) begin
                d = {R0, G0, B0, R1, G1, B1};
                n_cmp++;
                if ({vsync, hsync, busy, Read_Done, mem_rd, mem_addr, d} !== '0) begin
                    n_bad++;
                    $display("FAIL midframe_reset got v=%b h=%b busy=%b done=%b rd=%b addr=%h data=%h want all zero",
                             vsync, hsync, busy, Read_Done, mem_rd, mem_addr, d);
                end
                HRESET = 1'b0;
            end
            if (rel == 18) begin
                n_cmp++;
                if ({busy, Read_Done, vsync} !== 3'b000) begin
                    n_bad++;
                    $display("FAIL post_reset_idle got busy=%b done=%b vsync=%b want 0 0 0",
                             busy, Read_Done, vsync);
                end
            end
        end
        HRESET = 1'b0;
        test_frame(0);
    endtask

    task automatic test_stride6();
        int exp_a;
        addr_q.delete();
        for (int a = 74; a <= 91; a++) addr_q.push_back(a);
        for (int a = 54; a <= 71; a++) addr_q.push_back(a);
        @(negedge HCLK);
        start6 = 1'b1;
        for (int i = 0; i < 90; i++) begin
            @(negedge HCLK);
            start6 = 1'b0;
            if (mem_rd6 === 1'b1) begin
                n_cmp++;
                if (mem_addr6 == 20'd92 || mem_addr6 == 20'd93) begin
                    n_bad++;
                    $display("FAIL padding_read got addr=%0d want no read of 92..93", mem_addr6);
                end
                n_cmp++;
                if (addr_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL extra_read got addr=%0d want none", mem_addr6);
                end else begin
                    exp_a = addr_q.pop_front();
                    if (mem_addr6 !== 20'(exp_a)) begin
                        n_bad++;
                        $display("FAIL stride_addr got %0d want %0d", mem_addr6, exp_a);
                    end
                end
            end
        end
        n_cmp++;
        if (addr_q.size() != 0 || Read_Done6 !== 1'b1) begin
            n_bad++;
            $display("FAIL stride_complete got left=%0d done=%b want left=0 done=1",
                     addr_q.size(), Read_Done6);
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_done_restart();
        test_busy_start();
        test_reset_midframe();
        test_stride6();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
